// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave receiver: synchronizes SCLK/CS/MOSI into CLK, deserializes MSB-first words
// and hands them out on a valid/ready pair. Define SPI_SLAVE_MISO_EN to add the MISO transmit path.
module spi_slave_rx #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  rst,
    input  logic                  SCLK,
    input  logic                  CS,
    input  logic                  MOSI,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  overrun,
    output logic                  frame_err,
    output logic [3:0]            led
`ifdef SPI_SLAVE_MISO_EN
    ,
    output logic                  MISO,
    input  logic [DATA_WIDTH-1:0] tx_data
`endif
);

    localparam int unsigned CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [3:0] LED_IDLE  = 4'b1111;
    localparam logic [3:0] LED_SHIFT = 4'b0001;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // Input synchronizers; the third SCLK/CS stage feeds edge detection.
    logic sclk_s1_q, sclk_s2_q, sclk_s3_q;
    logic cs_s1_q, cs_s2_q, cs_s3_q;
    logic mosi_s1_q, mosi_s2_q;

    logic sclk_rise_c;
    logic cs_rise_c;
    logic cs_fall_c;

    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [DATA_WIDTH-1:0]   word_q, word_d;
    logic                    done_d;
    logic                    done_q;
    logic                    done2_q;
    logic                    frame_err_q, frame_err_d;
    logic [3:0]              led_q, led_d;

    logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
    logic                    rx_valid_q, rx_valid_d;
    logic                    overrun_q, overrun_d;

    // CS chain resets low so a CS already low at release never looks like a new falling edge.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            sclk_s1_q <= 1'b0;
            sclk_s2_q <= 1'b0;
            sclk_s3_q <= 1'b0;
            cs_s1_q   <= 1'b0;
            cs_s2_q   <= 1'b0;
            cs_s3_q   <= 1'b0;
            mosi_s1_q <= 1'b0;
            mosi_s2_q <= 1'b0;
        end else begin
            sclk_s1_q <= SCLK;
            sclk_s2_q <= sclk_s1_q;
            sclk_s3_q <= sclk_s2_q;
            cs_s1_q   <= CS;
            cs_s2_q   <= cs_s1_q;
            cs_s3_q   <= cs_s2_q;
            mosi_s1_q <= MOSI;
            mosi_s2_q <= mosi_s1_q;
        end
    end

    assign sclk_rise_c = sclk_s2_q & ~sclk_s3_q;
    assign cs_rise_c   = cs_s2_q & ~cs_s3_q;
    assign cs_fall_c   = ~cs_s2_q & cs_s3_q;

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            word_q      <= '0;
            done_q      <= 1'b0;
            done2_q     <= 1'b0;
            frame_err_q <= 1'b0;
            led_q       <= LED_IDLE;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            word_q      <= word_d;
            done_q      <= done_d;
            done2_q     <= done_q;
            frame_err_q <= frame_err_d;
            led_q       <= led_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    // Framing FSM and deserializer; a CS rise takes priority over a coincident SCLK edge.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        word_d      = word_q;
        done_d      = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (cs_fall_c) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cs_rise_c) begin
                    state_d     = ST_IDLE;
                    cnt_d       = '0;
                    shift_d     = '0;
                    frame_err_d = (cnt_q != '0);
                end else if (sclk_rise_c) begin
                    shift_d = {shift_q[DATA_WIDTH-2:0], mosi_s2_q};
                    if (cnt_q == CNT_LAST) begin
                        cnt_d  = '0;
                        word_d = shift_d;
                        done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        led_d = (state_d == ST_IDLE) ? LED_IDLE : LED_SHIFT;
    end

    // Output handshake: a completed word is accepted only if the holding register is free or draining.
    always_comb begin
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = 1'b0;
        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
        if (done2_q) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = word_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;
    assign led       = led_q;

`ifdef SPI_SLAVE_MISO_EN
    logic                  sclk_fall_c;
    logic [DATA_WIDTH-1:0] tx_q, tx_d;

    assign sclk_fall_c = ~sclk_s2_q & sclk_s3_q;

    // TX shifter: cleared in IDLE, reloaded at CS fall and on the falling edge that follows a word boundary.
    always_comb begin
        tx_d = tx_q;
        if (state_q == ST_IDLE) begin
            tx_d = '0;
            if (cs_fall_c) begin
                tx_d = tx_data;
            end
        end else if (cs_rise_c) begin
            tx_d = '0;
        end else if (sclk_fall_c) begin
            if (cnt_q == '0) begin
                tx_d = tx_data;
            end else begin
                tx_d = {tx_q[DATA_WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            tx_q <= '0;
        end else begin
            tx_q <= tx_d;
        end
    end

    assign MISO = tx_q[DATA_WIDTH-1];
`endif

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed + randomized bench for spi_slave_rx acting as the SPI master and the word consumer.
module tb_spi_slave_rx;

    localparam int unsigned W = 8;
    localparam int H = 6;

    logic         CLK = 1'b0;
    logic         rst;
    logic         SCLK;
    logic         CS;
    logic         MOSI;
    logic [W-1:0] rx_data;
    logic         rx_valid;
    logic         rx_ready;
    logic         overrun;
    logic         frame_err;
    logic [3:0]   led;
`ifdef SPI_SLAVE_MISO_EN
    logic         MISO;
    logic [W-1:0] tx_data;
`endif

    int checks = 0;
    int failures = 0;

    logic [W-1:0] got_q[$];
    logic [W-1:0] exp_q[$];
    logic         miso_bits[$];
    int           ovr_n = 0;
    int           ferr_n = 0;
    logic         v_prev = 1'b0;

    always #5 CLK = ~CLK;

    spi_slave_rx #(.DATA_WIDTH(W)) dut (
        .CLK      (CLK),
        .rst      (rst),
        .SCLK     (SCLK),
        .CS       (CS),
        .MOSI     (MOSI),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .overrun  (overrun),
        .frame_err(frame_err),
        .led      (led)
`ifdef SPI_SLAVE_MISO_EN
        ,
        .MISO     (MISO),
        .tx_data  (tx_data)
`endif
    );

    // Observer: records delivered words and counts status pulses shortly after each edge.
    always @(posedge CLK) begin
        #2;
        if (rx_valid && !v_prev) got_q.push_back(rx_data);
        v_prev = rx_valid;
        if (overrun) ovr_n++;
        if (frame_err) ferr_n++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] got_at(input int idx);
        if (idx < got_q.size()) return got_q[idx];
        return 'x;
    endfunction

    task automatic clear_obs();
        got_q.delete();
        exp_q.delete();
        miso_bits.delete();
        ovr_n = 0;
        ferr_n = 0;
    endtask

    task automatic cs_start();
        CS = 1'b0;
        repeat (8) @(negedge CLK);
    endtask

    task automatic cs_end();
        repeat (H) @(negedge CLK);
        CS = 1'b1;
        repeat (12) @(negedge CLK);
    endtask

    // Master sends the top nbits of w, MSB first; optionally checks rx_valid latency on the last bit.
    task automatic send_word(input logic [W-1:0] w, input int nbits, input bit chk_lat);
        for (int i = 0; i < nbits; i++) begin
            MOSI = w[W-1-i];
            repeat (H) @(negedge CLK);
`ifdef SPI_SLAVE_MISO_EN
            miso_bits.push_back(MISO);
`endif
            SCLK = 1'b1;
            if (chk_lat && i == nbits - 1) begin
                repeat (4) @(negedge CLK);
                check("latency_pre", 32'(rx_valid), 32'd0);
                @(negedge CLK);
                check("latency_hit", 32'(rx_valid), 32'd1);
                repeat (H - 5) @(negedge CLK);
            end else begin
                repeat (H) @(negedge CLK);
            end
            SCLK = 1'b0;
        end
    endtask

    initial begin
        logic [W-1:0] w;
        int nw;
        rst = 1'b1;
        SCLK = 1'b0;
        CS = 1'b1;
        MOSI = 1'b0;
        rx_ready = 1'b1;
`ifdef SPI_SLAVE_MISO_EN
        tx_data = '0;
`endif
        repeat (3) @(negedge CLK);
        check("rst_rx_data", 32'(rx_data), 32'h0);
        check("rst_rx_valid", 32'(rx_valid), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        check("rst_led", 32'(led), 32'hF);
        rst = 1'b0;
        repeat (4) @(negedge CLK);

        // Single word 0xAA with latency check
        clear_obs();
        cs_start();
        check("led_shift", 32'(led), 32'h1);
        send_word(8'hAA, 8, 1'b1);
        cs_end();
        check("aa_count", 32'(got_q.size()), 32'd1);
        check("aa_data", 32'(got_at(0)), 32'hAA);
        check("aa_overrun", 32'(ovr_n), 32'd0);
        check("aa_frame_err", 32'(ferr_n), 32'd0);
        check("aa_led_idle", 32'(led), 32'hF);

        // Two words in one CS-low frame
        clear_obs();
        cs_start();
        send_word(8'h3C, 8, 1'b0);
        send_word(8'hC3, 8, 1'b0);
        cs_end();
        check("mw_count", 32'(got_q.size()), 32'd2);
        check("mw_first", 32'(got_at(0)), 32'h3C);
        check("mw_second", 32'(got_at(1)), 32'hC3);

        // CS raised mid-word
        clear_obs();
        cs_start();
        send_word(8'hB7, 5, 1'b0);
        cs_end();
        check("fe_pulses", 32'(ferr_n), 32'd1);
        check("fe_no_valid", 32'(got_q.size()), 32'd0);
        check("fe_led", 32'(led), 32'hF);

        // Consumer stalled: second word dropped
        clear_obs();
        rx_ready = 1'b0;
        cs_start();
        send_word(8'h11, 8, 1'b0);
        send_word(8'h22, 8, 1'b0);
        cs_end();
        check("ovr_data", 32'(rx_data), 32'h11);
        check("ovr_valid", 32'(rx_valid), 32'd1);
        check("ovr_pulses", 32'(ovr_n), 32'd1);
        rx_ready = 1'b1;
        @(negedge CLK);
        check("ovr_drain", 32'(rx_valid), 32'd0);

        // Reset mid-word, then a clean frame
        clear_obs();
        cs_start();
        send_word(8'hF0, 3, 1'b0);
        rst = 1'b1;
        @(negedge CLK);
        check("mrst_rx_data", 32'(rx_data), 32'h0);
        check("mrst_rx_valid", 32'(rx_valid), 32'h0);
        check("mrst_overrun", 32'(overrun), 32'h0);
        check("mrst_frame_err", 32'(frame_err), 32'h0);
        check("mrst_led", 32'(led), 32'hF);
        repeat (2) @(negedge CLK);
        rst = 1'b0;
        repeat (4) @(negedge CLK);
        CS = 1'b1;
        repeat (12) @(negedge CLK);
        clear_obs();
        cs_start();
        send_word(8'h0F, 8, 1'b0);
        cs_end();
        check("mrst_count", 32'(got_q.size()), 32'd1);
        check("mrst_word", 32'(rx_data), 32'h0F);
        check("mrst_fe", 32'(ferr_n), 32'd0);

        // Random frames: with the consumer always ready every word is delivered in order
        clear_obs();
        for (int f = 0; f < 4; f++) begin
            nw = int'($urandom_range(1, 3));
            cs_start();
            for (int k = 0; k < nw; k++) begin
                w = W'($urandom);
                exp_q.push_back(w);
                send_word(w, 8, 1'b0);
            end
            cs_end();
        end
        check("rnd_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++) begin
            check($sformatf("rnd_word%0d", k), 32'(got_at(k)), 32'(exp_q[k]));
        end
        check("rnd_overrun", 32'(ovr_n), 32'd0);
        check("rnd_frame_err", 32'(ferr_n), 32'd0);

`ifdef SPI_SLAVE_MISO_EN
        // Transmit path: 0x5A shifted out MSB first while receiving 0x00
        begin
            logic exp_bits [8];
            exp_bits = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
            clear_obs();
            tx_data = 8'h5A;
            check("miso_idle", 32'(MISO), 32'd0);
            cs_start();
            send_word(8'h00, 8, 1'b0);
            cs_end();
            check("miso_nbits", 32'(miso_bits.size()), 32'd8);
            for (int k = 0; k < 8; k++) begin
                check($sformatf("miso_bit%0d", k),
                      32'(k < miso_bits.size() ? miso_bits[k] : 1'bx), 32'(exp_bits[k]));
            end
            check("miso_rx", 32'(got_at(0)), 32'h00);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
